// File: rtl/seq_sched_pkg.sv
// Shared types for the round-robin scheduled sequence detector.
// Holds the scheduler state encoding and the default detect pattern.
package seq_sched_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      REPORT
   } sched_state_t;

   localparam logic [3:0] DEFAULT_PATTERN = 4'b1010;

endpackage

// File: rtl/pat_detect_ovl.sv
// Overlapping serial pattern detector; match is Mealy on the incoming bit.
// No backpressure: one bit is consumed on every bit_vld cycle, clr wipes history.
module pat_detect_ovl
   import seq_sched_pkg::*;
#(
   parameter int               PAT_W   = 4,
   parameter logic [PAT_W-1:0] PATTERN = DEFAULT_PATTERN
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic bit_vld,
   input  logic bit_i,
   output logic match
);

   localparam int              FILL_W   = $clog2(PAT_W);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

   logic [PAT_W-2:0]  hist;
   logic [FILL_W-1:0] fill;
   logic [PAT_W-1:0]  win;

   assign win   = {hist, bit_i};
   // fill saturates, so equality means "at least PAT_W-1 bits of history"
   assign match = bit_vld && (fill == FILL_MAX) && (win == PATTERN);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hist <= '0;
         fill <= '0;
      end else if (clr) begin
         hist <= '0;
         fill <= '0;
      end else if (bit_vld) begin
         hist <= win[PAT_W-2:0];
         if (fill != FILL_MAX) fill <= fill + 1'b1;
      end
   end

endmodule

// File: rtl/seq_detect_sched.sv
// Round-robin share of one overlap detector; result WORD_W+1 cycles after accept.
// Result held until res_ready; SEQ_FIRST_POS_EN adds res_first_pos output.
module seq_detect_sched
   import seq_sched_pkg::*;
#(
   parameter int               NREQ    = 4,
   parameter int               WORD_W  = 16,
   parameter int               PAT_W   = 4,
   parameter logic [PAT_W-1:0] PATTERN = DEFAULT_PATTERN,
   localparam int              ID_W    = $clog2(NREQ),
   localparam int              CNT_W   = $clog2(WORD_W + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ*WORD_W-1:0] word_i,
   output logic [NREQ-1:0]        ack_o,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [ID_W-1:0]        res_id,
   output logic [CNT_W-1:0]       res_count,
`ifdef SEQ_FIRST_POS_EN
   output logic [CNT_W-1:0]       res_first_pos,
`endif
   output logic                   busy
);

   localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

   sched_state_t      state, state_nxt;
   logic [ID_W-1:0]   last_grant;
   logic [ID_W-1:0]   gnt_id;
   logic [ID_W-1:0]   cand;
   logic              gnt_vld;
   logic              accept;
   logic [WORD_W-1:0] sreg;
   logic [BIT_W-1:0]  bitcnt;
   logic              last_bit;
   logic              match;
   logic [CNT_W-1:0]  count;
   logic [ID_W-1:0]   id_q;

   // first requester strictly after last_grant, wrapping around
   always_comb begin
      gnt_vld = 1'b0;
      gnt_id  = '0;
      cand    = '0;
      for (int i = 1; i <= NREQ; i++) begin
         cand = ID_W'((int'(last_grant) + i) % NREQ);
         if (!gnt_vld && req[cand]) begin
            gnt_vld = 1'b1;
            gnt_id  = cand;
         end
      end
   end

   assign last_bit = (bitcnt == BIT_W'(WORD_W - 1));

   // ack is combinational; gating with rst keeps it low while reset is held
   always_comb begin
      state_nxt = state;
      ack_o     = '0;
      case (state)
         IDLE: begin
            if (gnt_vld && rst) begin
               ack_o[gnt_id] = 1'b1;
               state_nxt     = SHIFT;
            end
         end
         SHIFT:   if (last_bit) state_nxt = REPORT;
         REPORT:  if (res_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign accept = |ack_o;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_grant <= ID_W'(NREQ - 1);
         id_q       <= '0;
         sreg       <= '0;
         bitcnt     <= '0;
         count      <= '0;
      end else if (accept) begin
         last_grant <= gnt_id;
         id_q       <= gnt_id;
         sreg       <= word_i[gnt_id*WORD_W +: WORD_W];
         bitcnt     <= '0;
         count      <= '0;
      end else if (state == SHIFT) begin
         sreg   <= sreg << 1;
         bitcnt <= bitcnt + 1'b1;
         if (match) count <= count + 1'b1;
      end
   end

   pat_detect_ovl #(
      .PAT_W   (PAT_W),
      .PATTERN (PATTERN)
   ) u_det (
      .clk     (clk),
      .rst     (rst),
      .clr     (accept),
      .bit_vld (state == SHIFT),
      .bit_i   (sreg[WORD_W-1]),
      .match   (match)
   );

`ifdef SEQ_FIRST_POS_EN
   // all-ones doubles as "no match yet"; real indices never reach it
   logic [CNT_W-1:0] first_pos;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         first_pos <= '1;
      else if (accept)
         first_pos <= '1;
      else if ((state == SHIFT) && match && (first_pos == '1))
         first_pos <= CNT_W'(bitcnt);
   end

   assign res_first_pos = first_pos;
`endif

   assign res_valid = (state == REPORT);
   assign res_id    = id_q;
   assign res_count = count;
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_seq_detect_sched.sv
// Directed bench for seq_detect_sched: arbitration order, match counts,
// word-boundary isolation, result backpressure and mid-word reset.
module tb_seq_detect_sched;

   localparam int NREQ   = 4;
   localparam int WORD_W = 16;
   localparam int ID_W   = 2;
   localparam int CNT_W  = 5;
   localparam int LAT    = WORD_W + 1;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [NREQ-1:0]        req;
   logic [NREQ*WORD_W-1:0] word_i;
   logic [NREQ-1:0]        ack_o;
   logic                   res_valid;
   logic                   res_ready;
   logic [ID_W-1:0]        res_id;
   logic [CNT_W-1:0]       res_count;
   logic                   busy;
`ifdef SEQ_FIRST_POS_EN
   logic [CNT_W-1:0]       res_first_pos;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seq_detect_sched dut (
      .clk           (clk),
      .rst           (rst),
      .req           (req),
      .word_i        (word_i),
      .ack_o         (ack_o),
      .res_valid     (res_valid),
      .res_ready     (res_ready),
      .res_id        (res_id),
      .res_count     (res_count),
`ifdef SEQ_FIRST_POS_EN
      .res_first_pos (res_first_pos),
`endif
      .busy          (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Waits for the grant, follows the word to its result and checks it.
   task automatic run_word(input int id, input int cnt, input int fp, input int stall,
                           input int exp_wait, input bit drop);
      int   n;
      logic ack_seen;
      logic [ID_W-1:0] idx;
      idx = id[ID_W-1:0];
      n   = 0;
      while (ack_o == '0 && n < 40) begin
         @(negedge clk); #1;
         n++;
      end
      chk("ack_wait", n, exp_wait);
      chk("ack_onehot", 32'(ack_o), 32'(1) << id);
      chk("accept_busy", 32'(busy), 0);
      res_ready = (stall == 0);
      ack_seen  = 1'b0;
      n = 0;
      do begin
         @(negedge clk); #1;
         n++;
         if (n == 1 && drop) req[idx] = 1'b0;
         if (ack_o != '0) ack_seen = 1'b1;
      end while (!res_valid && n < 40);
      chk("latency", n, LAT);
      chk("ack_while_busy", 32'(ack_seen), 0);
      chk("res_id", 32'(res_id), id);
      chk("res_count", 32'(res_count), cnt);
`ifdef SEQ_FIRST_POS_EN
      chk("res_first_pos", 32'(res_first_pos), fp);
`endif
      for (int i = 0; i < stall; i++) begin
         @(negedge clk); #1;
         chk("stall_valid", 32'(res_valid), 1);
         chk("stall_id", 32'(res_id), id);
         chk("stall_count", 32'(res_count), cnt);
         chk("stall_ack", 32'(ack_o), 0);
      end
      res_ready = 1'b1;
   endtask

   initial begin
      rst       = 1'b0;
      req       = 4'b0001;
      res_ready = 1'b1;
      word_i    = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_ack", 32'(ack_o), 0);
      chk("rst_valid", 32'(res_valid), 0);
      chk("rst_id", 32'(res_id), 0);
      chk("rst_count", 32'(res_count), 0);
      chk("rst_busy", 32'(busy), 0);

      // single requester, alternating word
      word_i[0*WORD_W +: WORD_W] = 16'hAAAA;
      @(negedge clk);
      rst = 1'b1;
      #1;
      run_word(0, 7, 3, 0, 0, 1'b1);
      @(negedge clk); #1;
      chk("idle_valid", 32'(res_valid), 0);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_ack", 32'(ack_o), 0);

      // all requesters held: fresh reset so req[0] leads
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      word_i[0*WORD_W +: WORD_W] = 16'hAAAA;
      word_i[1*WORD_W +: WORD_W] = 16'hA0A0;
      word_i[2*WORD_W +: WORD_W] = 16'h000A;
      word_i[3*WORD_W +: WORD_W] = 16'h0000;
      req = 4'b1111;
      #1;
      run_word(0, 7, 3, 0, 0, 1'b0);
      run_word(1, 2, 3, 0, 1, 1'b0);
      run_word(2, 1, 15, 0, 1, 1'b0);
      run_word(3, 0, 31, 0, 1, 1'b0);
      req = '0;
      @(negedge clk); #1;
      chk("rr_idle_ack", 32'(ack_o), 0);

      // pattern straddling two words must not be counted
      word_i[0*WORD_W +: WORD_W] = 16'h0001;
      req = 4'b0001;
      #1;
      run_word(0, 0, 31, 0, 0, 1'b1);
      word_i[0*WORD_W +: WORD_W] = 16'h4000;
      req = 4'b0001;
      run_word(0, 0, 31, 0, 1, 1'b1);
      req = '0;
      @(negedge clk); #1;

      // result backpressure with another requester waiting
      word_i[1*WORD_W +: WORD_W] = 16'hA0A0;
      word_i[2*WORD_W +: WORD_W] = 16'h000A;
      req = 4'b0110;
      #1;
      run_word(1, 2, 3, 5, 0, 1'b1);
      run_word(2, 1, 15, 0, 1, 1'b1);
      req = '0;
      @(negedge clk); #1;

      // reset in the middle of a word
      word_i[0*WORD_W +: WORD_W] = 16'hAAAA;
      word_i[2*WORD_W +: WORD_W] = 16'hAAAA;
      req = 4'b0100;
      #1;
      chk("pre_rst_ack", 32'(ack_o), 32'b0100);
      repeat (8) @(negedge clk);
      #1;
      chk("mid_shift_busy", 32'(busy), 1);
      rst = 1'b0;
      req = 4'b0101;
      #1;
      chk("mid_rst_ack", 32'(ack_o), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_valid", 32'(res_valid), 0);
      chk("mid_rst_id", 32'(res_id), 0);
      chk("mid_rst_count", 32'(res_count), 0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      run_word(0, 7, 3, 0, 0, 1'b1);
      req = '0;
      @(negedge clk); #1;
      chk("final_busy", 32'(busy), 0);
      chk("final_ack", 32'(ack_o), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
